// File: rtl/ysyx_23060221_axi_arbiter.sv
// rtl/ysyx_23060221_axi_arbiter.sv - two-master round-robin AXI4 arbiter, one whole transaction per grant
module ysyx_23060221_axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    // master 0 (IFU)
    input  logic        m0_arvalid,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_arready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    output logic [3:0]  m0_rid,
    input  logic        m0_rready,
    input  logic        m0_awvalid,
    input  logic [31:0] m0_awaddr,
    input  logic [3:0]  m0_awid,
    input  logic [7:0]  m0_awlen,
    input  logic [2:0]  m0_awsize,
    input  logic [1:0]  m0_awburst,
    output logic        m0_awready,
    input  logic        m0_wvalid,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wlast,
    output logic        m0_wready,
    output logic        m0_bvalid,
    output logic [1:0]  m0_bresp,
    output logic [3:0]  m0_bid,
    input  logic        m0_bready,
    // master 1 (LSU)
    input  logic        m1_arvalid,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_arready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    output logic [3:0]  m1_rid,
    input  logic        m1_rready,
    input  logic        m1_awvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awid,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    output logic        m1_awready,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [1:0]  m1_bresp,
    output logic [3:0]  m1_bid,
    input  logic        m1_bready,
    // slave port
    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_rready,
    output logic        s_awvalid,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    input  logic        s_awready,
    output logic        s_wvalid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_wready,
    input  logic        s_bvalid,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid,
    output logic        s_bready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic in_rd, in_wr, active;
    logic rd0, rd1, wr0, wr1;
    logic req0, req1, winner;
    logic rd_complete, wr_complete;

    assign in_rd  = (state_q == RD);
    assign in_wr  = (state_q == WR);
    assign active = in_rd | in_wr;
    assign rd0    = in_rd & ~owner_q;
    assign rd1    = in_rd &  owner_q;
    assign wr0    = in_wr & ~owner_q;
    assign wr1    = in_wr &  owner_q;
    assign busy   = active;

    // Owner-side view of both masters' request signals
    logic        own_arvalid, own_rready, own_awvalid, own_wvalid, own_wlast, own_bready;
    logic [31:0] own_araddr, own_awaddr, own_wdata;
    logic [3:0]  own_arid, own_awid, own_wstrb;
    logic [7:0]  own_arlen, own_awlen;
    logic [2:0]  own_arsize, own_awsize;
    logic [1:0]  own_arburst, own_awburst;

    assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign own_araddr  = owner_q ? m1_araddr  : m0_araddr;
    assign own_arid    = owner_q ? m1_arid    : m0_arid;
    assign own_arlen   = owner_q ? m1_arlen   : m0_arlen;
    assign own_arsize  = owner_q ? m1_arsize  : m0_arsize;
    assign own_arburst = owner_q ? m1_arburst : m0_arburst;
    assign own_rready  = owner_q ? m1_rready  : m0_rready;
    assign own_awvalid = owner_q ? m1_awvalid : m0_awvalid;
    assign own_awaddr  = owner_q ? m1_awaddr  : m0_awaddr;
    assign own_awid    = owner_q ? m1_awid    : m0_awid;
    assign own_awlen   = owner_q ? m1_awlen   : m0_awlen;
    assign own_awsize  = owner_q ? m1_awsize  : m0_awsize;
    assign own_awburst = owner_q ? m1_awburst : m0_awburst;
    assign own_wvalid  = owner_q ? m1_wvalid  : m0_wvalid;
    assign own_wdata   = owner_q ? m1_wdata   : m0_wdata;
    assign own_wstrb   = owner_q ? m1_wstrb   : m0_wstrb;
    assign own_wlast   = owner_q ? m1_wlast   : m0_wlast;
    assign own_bready  = owner_q ? m1_bready  : m0_bready;

    // Slave side: valids gated so each address/data phase is issued once
    assign s_arvalid = in_rd & own_arvalid & ~ar_done_q;
    assign s_araddr  = active ? own_araddr  : '0;
    assign s_arid    = active ? own_arid    : '0;
    assign s_arlen   = active ? own_arlen   : '0;
    assign s_arsize  = active ? own_arsize  : '0;
    assign s_arburst = active ? own_arburst : '0;
    assign s_rready  = in_rd & own_rready;
    assign s_awvalid = in_wr & own_awvalid & ~aw_done_q;
    assign s_awaddr  = active ? own_awaddr  : '0;
    assign s_awid    = active ? own_awid    : '0;
    assign s_awlen   = active ? own_awlen   : '0;
    assign s_awsize  = active ? own_awsize  : '0;
    assign s_awburst = active ? own_awburst : '0;
    assign s_wvalid  = in_wr & own_wvalid & ~w_done_q;
    assign s_wdata   = active ? own_wdata : '0;
    assign s_wstrb   = active ? own_wstrb : '0;
    assign s_wlast   = active ? own_wlast : 1'b0;
    assign s_bready  = in_wr & own_bready;

    // Master side: the non-owner sees an idle port
    assign m0_arready = rd0 & s_arready & ~ar_done_q;
    assign m0_rvalid  = rd0 & s_rvalid;
    assign m0_rdata   = rd0 ? s_rdata : '0;
    assign m0_rresp   = rd0 ? s_rresp : '0;
    assign m0_rlast   = rd0 & s_rlast;
    assign m0_rid     = rd0 ? s_rid : '0;
    assign m0_awready = wr0 & s_awready & ~aw_done_q;
    assign m0_wready  = wr0 & s_wready & ~w_done_q;
    assign m0_bvalid  = wr0 & s_bvalid;
    assign m0_bresp   = wr0 ? s_bresp : '0;
    assign m0_bid     = wr0 ? s_bid : '0;

    assign m1_arready = rd1 & s_arready & ~ar_done_q;
    assign m1_rvalid  = rd1 & s_rvalid;
    assign m1_rdata   = rd1 ? s_rdata : '0;
    assign m1_rresp   = rd1 ? s_rresp : '0;
    assign m1_rlast   = rd1 & s_rlast;
    assign m1_rid     = rd1 ? s_rid : '0;
    assign m1_awready = wr1 & s_awready & ~aw_done_q;
    assign m1_wready  = wr1 & s_wready & ~w_done_q;
    assign m1_bvalid  = wr1 & s_bvalid;
    assign m1_bresp   = wr1 ? s_bresp : '0;
    assign m1_bid     = wr1 ? s_bid : '0;

    assign req0        = m0_arvalid | m0_awvalid;
    assign req1        = m1_arvalid | m1_awvalid;
    assign winner      = (req0 & req1) ? ~last_q : req1;
    assign rd_complete = s_rvalid & s_rready & s_rlast;
    assign wr_complete = s_bvalid & s_bready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = winner;
                    state_d = (winner ? m1_arvalid : m0_arvalid) ? RD : WR;
                end
            end
            RD: begin
                if (s_arvalid & s_arready) ar_done_d = 1'b1;
                if (rd_complete) begin
                    state_d   = IDLE;
                    last_d    = owner_q;
                    ar_done_d = 1'b0;
                end
            end
            WR: begin
                if (s_awvalid & s_awready)          aw_done_d = 1'b1;
                if (s_wvalid & s_wready & s_wlast)  w_done_d  = 1'b1;
                // B may legally arrive before the done flags settle; it still ends the grant
                if (wr_complete) begin
                    state_d   = IDLE;
                    last_d    = owner_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060221_axi_arbiter.sv
// tb/tb_ysyx_23060221_axi_arbiter.sv - directed self-checking bench for the two-master AXI arbiter
module tb_ysyx_23060221_axi_arbiter;

    logic        clk, rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wlast, m0_wready, m0_bvalid, m0_bready;
    logic [31:0] m0_awaddr, m0_wdata;
    logic [3:0]  m0_awid, m0_wstrb, m0_bid;
    logic [7:0]  m0_awlen;
    logic [2:0]  m0_awsize;
    logic [1:0]  m0_awburst, m0_bresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [3:0]  m1_arid, m1_rid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_awid, m1_wstrb, m1_bid;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_wstrb, s_bid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int aw_base, w_base;

    ysyx_23060221_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
        .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
        .m0_bready(m0_bready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
        .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_bready(s_bready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_awvalid && s_awready) aw_hs++;
        if (s_wvalid && s_wready)   w_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Single-beat read by the current owner; slave answers lat cycles after AR
    task automatic serve_read(input logic who, input logic [31:0] addr, input logic [31:0] data, input int lat);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_araddr", s_araddr, addr);
        chk("rd_arvalid", 32'(s_arvalid), 32'd1);
        s_arready = 1'b1;
        #1;
        chk("rd_arready_owner", 32'(who ? m1_arready : m0_arready), 32'd1);
        chk("rd_arready_other", 32'(who ? m0_arready : m1_arready), 32'd0);
        tick();
        s_arready = 1'b0;
        #1;
        chk("rd_ar_once", 32'(s_arvalid), 32'd0);
        if (who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        repeat (lat) tick();
        s_rvalid = 1'b1; s_rdata = data; s_rresp = 2'b00; s_rlast = 1'b1; s_rid = {3'b0, who};
        #1;
        chk("rd_rdata", who ? m1_rdata : m0_rdata, data);
        chk("rd_rid", 32'(who ? m1_rid : m0_rid), 32'(who));
        chk("rd_rvalid_other", 32'(who ? m0_rvalid : m1_rvalid), 32'd0);
        tick();
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        #1;
        chk("rd_busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
        {m0_awvalid, m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst} = '0;
        {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast} = '0;
        {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
        {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
        {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast} = '0;
        m0_rready = 1'b1; m0_bready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        {s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = '0;
        {s_awready, s_wready, s_bvalid, s_bresp, s_bid} = '0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("reset_s_awvalid", 32'(s_awvalid), 32'd0);
        chk("reset_m0_arready", 32'(m0_arready), 32'd0);
        rst = 1'b1;
        tick();

        // Single IFU read, two-cycle slave latency
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arsize = 3'd2; m0_arburst = 2'b01;
        #1;
        chk("t1_arvalid_not_yet", 32'(s_arvalid), 32'd0);
        tick();
        serve_read(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 2);

        // Simultaneous reads after reset: m0 first, m1 after one idle cycle
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0100;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0200;
        tick();
        serve_read(1'b0, 32'h0000_0100, 32'h1111_0000, 0);
        chk("t2_idle_gap_m1_arready", 32'(m1_arready), 32'd0);
        tick();
        serve_read(1'b1, 32'h0000_0200, 32'h2222_0000, 0);

        // Four simultaneous rounds alternate winners; loser withdraws each round
        for (int r = 0; r < 4; r++) begin
            m0_arvalid = 1'b1;
            m1_arvalid = 1'b1;
            tick();
            serve_read(1'(r % 2), (r % 2) ? 32'h0000_0200 : 32'h0000_0100, 32'h3000_0000 + 32'(r), 0);
            m0_arvalid = 1'b0;
            m1_arvalid = 1'b0;
            tick();
        end

        // LSU write, slave takes W before AW, m0 read held off meanwhile
        m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0004; m1_awid = 4'd5;
        m1_wvalid = 1'b1; m1_wdata = 32'h1122_3344; m1_wstrb = 4'b1100; m1_wlast = 1'b1;
        aw_base = aw_hs; w_base = w_hs;
        tick();
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0C00;
        #1;
        chk("t3_awaddr", s_awaddr, 32'h8000_0004);
        chk("t3_wdata", s_wdata, 32'h1122_3344);
        chk("t3_wstrb", 32'(s_wstrb), 32'hC);
        chk("t3_s_arvalid", 32'(s_arvalid), 32'd0);
        s_wready = 1'b1;
        #1;
        chk("t3_m1_wready", 32'(m1_wready), 32'd1);
        chk("t3_m1_awready", 32'(m1_awready), 32'd0);
        chk("t3_m0_arready", 32'(m0_arready), 32'd0);
        tick();
        s_wready = 1'b0;
        chk("t3_w_once", 32'(s_wvalid), 32'd0);
        m1_wvalid = 1'b0;
        chk("t3_aw_pending", 32'(s_awvalid), 32'd1);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        chk("t3_aw_once", 32'(s_awvalid), 32'd0);
        m1_awvalid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b10; s_bid = 4'd5;
        #1;
        chk("t3_m1_bvalid", 32'(m1_bvalid), 32'd1);
        chk("t3_m1_bresp", 32'(m1_bresp), 32'd2);
        chk("t3_m1_bid", 32'(m1_bid), 32'd5);
        chk("t3_m0_bvalid", 32'(m0_bvalid), 32'd0);
        chk("t3_m0_arready_b", 32'(m0_arready), 32'd0);
        tick();
        s_bvalid = 1'b0; s_bresp = 2'b00; s_bid = 4'd0;
        #1;
        chk("t3_busy_after", 32'(busy), 32'd0);
        chk("t3_aw_count", 32'(aw_hs - aw_base), 32'd1);
        chk("t3_w_count", 32'(w_hs - w_base), 32'd1);
        tick();
        serve_read(1'b0, 32'h0000_0C00, 32'h0C0C_0C0C, 1);

        // m1 read+write together, m0 joins: read, then m0, then the write
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0D00;
        m1_awvalid = 1'b1; m1_awaddr = 32'h0000_0E00;
        m1_wvalid = 1'b1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF; m1_wlast = 1'b1;
        tick();
        chk("t4_no_aw_in_read", 32'(s_awvalid), 32'd0);
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0F00;
        serve_read(1'b1, 32'h0000_0D00, 32'hD0D0_D0D0, 0);
        tick();
        chk("t4_m0_next_aw", 32'(s_awvalid), 32'd0);
        serve_read(1'b0, 32'h0000_0F00, 32'hF0F0_F0F0, 0);
        tick();
        chk("t4_write_awvalid", 32'(s_awvalid), 32'd1);
        chk("t4_write_awaddr", s_awaddr, 32'h0000_0E00);
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        s_awready = 1'b0; s_wready = 1'b0;
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_bvalid = 1'b1;
        #1;
        chk("t4_m1_bvalid", 32'(m1_bvalid), 32'd1);
        tick();
        s_bvalid = 1'b0;
        #1;
        chk("t4_busy_after", 32'(busy), 32'd0);

        // Four-beat burst by m0, SLVERR on beat 2, m1 waits for rlast
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0400; m0_arlen = 8'd3;
        tick();
        chk("t5_arlen", 32'(s_arlen), 32'd3);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        m0_arvalid = 1'b0; m0_arlen = 8'd0;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0500;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = 1'b1;
            s_rlast  = (i == 3);
            s_rresp  = (i == 2) ? 2'b10 : 2'b00;
            s_rdata  = 32'h0000_B000 + 32'(i);
            #1;
            chk("t5_beat_rdata", m0_rdata, 32'h0000_B000 + 32'(i));
            chk("t5_beat_rresp", 32'(m0_rresp), (i == 2) ? 32'd2 : 32'd0);
            chk("t5_beat_busy", 32'(busy), 32'd1);
            chk("t5_beat_m1_arready", 32'(m1_arready), 32'd0);
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00; s_rdata = '0;
        #1;
        chk("t5_busy_after", 32'(busy), 32'd0);
        tick();
        serve_read(1'b1, 32'h0000_0500, 32'h5555_0000, 0);

        // Reset between AR and R abandons the read
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0600;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        m0_arvalid = 1'b0;
        chk("t6_busy_before", 32'(busy), 32'd1);
        s_rvalid = 1'b1; s_rdata = 32'hAAAA_5555; s_rlast = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("t6_rst_m0_rdata", m0_rdata, 32'd0);
        chk("t6_rst_s_rready", 32'(s_rready), 32'd0);
        chk("t6_rst_s_araddr", s_araddr, 32'd0);
        s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
        tick();
        rst = 1'b1;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0700;
        tick();
        serve_read(1'b1, 32'h0000_0700, 32'h7777_7777, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
